aidan_mcnay_prime_search_ctrl: RTL and testbench

Parametrised control FSM for the prime detector. It tests one latched candidate by trial division across `NLANES` external divider units running in parallel, one divisor per lane per round. It reports prime/composite and the smallest factor found. It sits between the input SIPO/latch and a bank of val/rdy dividers, and replaces the single-lane controller.

---
 rtl/aidan_mcnay_prime_pkg.sv | 23 ++
 rtl/aidan_mcnay_div_lane_ctrl.sv | 80 ++++++++
 rtl/aidan_mcnay_prime_search_ctrl.sv | 158 +++++++++++++++
 tb/tb_aidan_mcnay_prime_search_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aidan_mcnay_prime_pkg.sv
// Shared definitions for the multi-lane prime search controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aidan_mcnay_prime_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Smallest trial divisor; every search starts its first round here.
  localparam int MIN_DIVISOR = 2;
  localparam int MAX_LANES   = 8;

  // Legal lane counts for the divider bank.
  function automatic bit lanes_ok(input int n);
    return (n >= 1) && (n <= MAX_LANES);
  endfunction

endpackage

// File: rtl/aidan_mcnay_div_lane_ctrl.sv
// One divider lane: activity test, issue/return tracking, zero-remainder capture.
// Latency: flags update one cycle after the val&rdy handshake.
// Backpressure: request held until istream_rdy; response accepted once per round.
// Optional: PRIME_SQRT_BOUND_EN selects the d*d <= cand activity bound.
module aidan_mcnay_div_lane_ctrl
  import aidan_mcnay_prime_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int LANE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NBITS:0]   base,
  input  logic [NBITS-1:0] cand,
  input  logic             issue_phase,
  input  logic             wait_phase,
  input  logic             clear,
  output logic [NBITS-1:0] divisor,
  output logic             istream_val,
  input  logic             istream_rdy,
  input  logic             ostream_val,
  output logic             ostream_rdy,
  input  logic [NBITS-1:0] remainder,
  output logic             issue_done,
  output logic             return_done,
  output logic             rem_zero
);

  logic [NBITS:0] lane_div;
  logic           active;
  logic           issued;
  logic           returned;
  logic           rem_zero_r;
  logic           issue_fire;
  logic           ret_fire;

  assign lane_div = base + (NBITS+1)'(LANE);
  assign divisor  = lane_div[NBITS-1:0];

`ifdef PRIME_SQRT_BOUND_EN
  // Stop at floor(sqrt(cand)); the square is wide enough to never wrap.
  logic [2*NBITS+1:0] lane_sq;
  assign lane_sq = {{(NBITS+1){1'b0}}, lane_div} * {{(NBITS+1){1'b0}}, lane_div};
  assign active  = (lane_sq <= {{(NBITS+2){1'b0}}, cand});
`else
  // Linear bound: try every divisor below the candidate.
  assign active = (lane_div < {1'b0, cand});
`endif

  // Outputs depend only on registered state, never on the incoming handshakes.
  assign istream_val = issue_phase & active & ~issued;
  assign ostream_rdy = wait_phase & issued & ~returned;
  assign issue_fire  = istream_val & istream_rdy;
  assign ret_fire    = ostream_rdy & ostream_val;

  // Completion includes this cycle's handshake so a round can advance immediately.
  assign issue_done  = ~active | issued | issue_fire;
  assign return_done = ~active | returned | ret_fire;
  assign rem_zero    = rem_zero_r & returned;

  // Per-round progress flags; cleared in EVAL before the next round starts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issued     <= 1'b0;
      returned   <= 1'b0;
      rem_zero_r <= 1'b0;
    end else if (clear) begin
      issued     <= 1'b0;
      returned   <= 1'b0;
      rem_zero_r <= 1'b0;
    end else begin
      if (issue_fire) issued <= 1'b1;
      if (ret_fire) begin
        returned   <= 1'b1;
        rem_zero_r <= (remainder == '0);
      end
    end
  end

endmodule

// File: rtl/aidan_mcnay_prime_search_ctrl.sv
// Prime test by parallel trial division over NLANES external val/rdy dividers.
// Latency: done one cycle after start for trivial inputs, else 3+ cycles per round.
// Backpressure: lanes handshake independently; start ignored while busy.
// Optional: PRIME_SQRT_BOUND_EN bounds the search at floor(sqrt(value)).
module aidan_mcnay_prime_search_ctrl
  import aidan_mcnay_prime_pkg::*;
#(
  parameter int NBITS  = 16,
  parameter int NLANES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [NBITS-1:0]        value,
  output logic                    busy,
  output logic [NLANES-1:0]       div_istream_val,
  input  logic [NLANES-1:0]       div_istream_rdy,
  output logic [NLANES*NBITS-1:0] div_divisor,
  output logic [NBITS-1:0]        div_dividend,
  input  logic [NLANES-1:0]       div_ostream_val,
  output logic [NLANES-1:0]       div_ostream_rdy,
  input  logic [NLANES*NBITS-1:0] div_remainder,
  output logic                    done,
  output logic                    is_prime,
  output logic [NBITS-1:0]        factor
);

  if (!lanes_ok(NLANES)) begin : g_bad_lanes
    $error("NLANES must be between 1 and 8");
  end

  state_t           state_r;
  state_t           state_nxt;
  logic [NBITS-1:0] cand_r;
  logic [NBITS:0]   base_r;
  logic [NBITS:0]   next_base;
  logic             is_prime_r;
  logic [NBITS-1:0] factor_r;
  logic             start_acc;
  logic             start_lane0;
  logic             next_lane0;

  logic [NBITS-1:0]  lane_div [NLANES];
  logic [NLANES-1:0] issue_done;
  logic [NLANES-1:0] return_done;
  logic [NLANES-1:0] hit;
  logic              hit_any;
  logic [NBITS-1:0]  hit_factor;

  // Lane-0 activity for a prospective base, used to decide whether a round is needed.
  function automatic logic lane0_active(input logic [NBITS:0] d, input logic [NBITS-1:0] c);
`ifdef PRIME_SQRT_BOUND_EN
    logic [2*NBITS+1:0] sq;
    sq = {{(NBITS+1){1'b0}}, d} * {{(NBITS+1){1'b0}}, d};
    return sq <= {{(NBITS+2){1'b0}}, c};
`else
    return d < {1'b0, c};
`endif
  endfunction

  assign busy         = (state_r == ST_ISSUE) || (state_r == ST_WAIT) || (state_r == ST_EVAL);
  assign done         = (state_r == ST_DONE);
  assign is_prime     = is_prime_r;
  assign factor       = factor_r;
  assign div_dividend = cand_r;

  assign start_acc   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign start_lane0 = lane0_active((NBITS+1)'(MIN_DIVISOR), value);
  assign next_base   = base_r + (NBITS+1)'(NLANES);
  assign next_lane0  = lane0_active(next_base, cand_r);

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    aidan_mcnay_div_lane_ctrl #(
      .NBITS (NBITS),
      .LANE  (i)
    ) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .base        (base_r),
      .cand        (cand_r),
      .issue_phase (state_r == ST_ISSUE),
      .wait_phase  (state_r == ST_WAIT),
      .clear       (state_r == ST_EVAL),
      .divisor     (lane_div[i]),
      .istream_val (div_istream_val[i]),
      .istream_rdy (div_istream_rdy[i]),
      .ostream_val (div_ostream_val[i]),
      .ostream_rdy (div_ostream_rdy[i]),
      .remainder   (div_remainder[i*NBITS +: NBITS]),
      .issue_done  (issue_done[i]),
      .return_done (return_done[i]),
      .rem_zero    (hit[i])
    );
    // Divisors read as zero outside an active search.
    assign div_divisor[i*NBITS +: NBITS] = busy ? lane_div[i] : '0;
  end

  // Lowest-index lane with a zero remainder supplies the smallest factor.
  always_comb begin
    hit_any    = |hit;
    hit_factor = '0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (hit[i]) hit_factor = lane_div[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (value < NBITS'(MIN_DIVISOR)) state_nxt = ST_DONE;
          else if (!start_lane0)           state_nxt = ST_DONE;
          else                             state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (&issue_done)  state_nxt = ST_WAIT;
      ST_WAIT:  if (&return_done) state_nxt = ST_EVAL;
      ST_EVAL: begin
        if (hit_any)          state_nxt = ST_DONE;
        else if (!next_lane0) state_nxt = ST_DONE;
        else                  state_nxt = ST_ISSUE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Candidate latch, base counter and held results.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand_r     <= '0;
      base_r     <= '0;
      is_prime_r <= 1'b0;
      factor_r   <= '0;
    end else if (start_acc) begin
      cand_r     <= value;
      base_r     <= (NBITS+1)'(MIN_DIVISOR);
      is_prime_r <= (value >= NBITS'(MIN_DIVISOR)) && !start_lane0;
      factor_r   <= '0;
    end else if (state_r == ST_EVAL) begin
      if (hit_any) begin
        is_prime_r <= 1'b0;
        factor_r   <= hit_factor;
      end else begin
        base_r <= next_base;
        if (!next_lane0) is_prime_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_prime_search_ctrl.sv
// Self-checking bench: randomized divider bank model plus arithmetic reference.
// Latency: n/a.
// Backpressure: bench varies lane ready and response delay per mode.
module tb_aidan_mcnay_prime_search_ctrl;

  localparam int NB = 16;
  localparam int NL = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [NB-1:0]    value;
  logic             busy;
  logic [NL-1:0]    div_istream_val;
  logic [NL-1:0]    div_istream_rdy;
  logic [NL*NB-1:0] div_divisor;
  logic [NB-1:0]    div_dividend;
  logic [NL-1:0]    div_ostream_val;
  logic [NL-1:0]    div_ostream_rdy;
  logic [NL*NB-1:0] div_remainder;
  logic             done;
  logic             is_prime;
  logic [NB-1:0]    factor;

  int checks = 0;
  int errors = 0;

  bit            pend [NL];
  int            dly  [NL];
  logic [NB-1:0] prem [NL];
  bit            seen [0:1023];

  aidan_mcnay_prime_search_ctrl #(.NBITS(NB), .NLANES(NL)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .value           (value),
    .busy            (busy),
    .div_istream_val (div_istream_val),
    .div_istream_rdy (div_istream_rdy),
    .div_divisor     (div_divisor),
    .div_dividend    (div_dividend),
    .div_ostream_val (div_ostream_val),
    .div_ostream_rdy (div_ostream_rdy),
    .div_remainder   (div_remainder),
    .done            (done),
    .is_prime        (is_prime),
    .factor          (factor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: which divisors the search is allowed to try.
  function automatic bit act(input int d, input int c);
`ifdef PRIME_SQRT_BOUND_EN
    return d * d <= c;
`else
    return d < c;
`endif
  endfunction

  function automatic int ref_factor(input int c);
    for (int d = 2; d < c; d++) if (c % d == 0) return d;
    return 0;
  endfunction

  function automatic bit ref_prime(input int c);
    return (c >= 2) && (ref_factor(c) == 0);
  endfunction

  // Rounds of NL consecutive divisors starting at 2 until a factor or the bound.
  function automatic int ref_rounds(input int c);
    int f;
    int r;
    if (c < 2 || !act(2, c)) return 0;
    f = ref_factor(c);
    if (f != 0) return (f - 2) / NL + 1;
    r = 0;
    while (act(2 + r * NL, c)) r++;
    return r;
  endfunction

  function automatic int ref_issues(input int c);
    int n = 0;
    for (int d = 2; d < 2 + ref_rounds(c) * NL; d++) if (act(d, c)) n++;
    return n;
  endfunction

  function automatic bit expected_divisor(input int d, input int c);
    return (d >= 2) && (d < 2 + ref_rounds(c) * NL) && act(d, c);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".busy"},     32'(busy), 0);
    check({tag, ".ival"},     32'(div_istream_val), 0);
    check({tag, ".ordy"},     32'(div_ostream_rdy), 0);
    check({tag, ".done"},     32'(done), 0);
    check({tag, ".is_prime"}, 32'(is_prime), 0);
    check({tag, ".factor"},   32'(factor), 0);
    check({tag, ".divisor"},  32'(div_divisor), 0);
    check({tag, ".dividend"}, 32'(div_dividend), 0);
  endtask

  // mode 0: always ready, 1-cycle response; 1: random ready/delay, junk responses,
  // starts while busy; 2: lane 1 stalled 5 cycles, lane 0 response delayed 3;
  // 3: like 0 but reset asserted on the first WAIT cycle.
  task automatic run(input int v, input int mode, output bit aborted);
    int            cyc;
    int            nissue;
    int            bad;
    int            d;
    bit            rdy;
    logic [NB-1:0] dv;
    aborted = 1'b0;
    for (int i = 0; i < NL; i++) begin
      pend[i] = 1'b0;
      dly[i]  = 0;
    end
    for (int k = 0; k < 1024; k++) seen[k] = 1'b0;
    div_istream_rdy = '0;
    div_ostream_val = '0;
    div_remainder   = '0;
    value = NB'(v);
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cyc    = 0;
    nissue = 0;
    bad    = 0;
    while (!done && cyc < 4000) begin
      if (mode == 3 && (|div_ostream_rdy)) begin
        reset_n = 1'b0;
        div_istream_rdy = '0;
        div_ostream_val = '0;
        @(posedge clk); #1;
        aborted = 1'b1;
        return;
      end
      for (int i = 0; i < NL; i++) begin
        dv = div_divisor[i*NB +: NB];
        if (div_istream_val[i] && !act(int'(dv), v)) bad++;
        if (div_ostream_rdy[i] && !pend[i]) bad++;
        // response side of the divider model
        if (pend[i] && dly[i] == 0) begin
          div_ostream_val[i] = 1'b1;
          div_remainder[i*NB +: NB] = prem[i];
          if (div_ostream_rdy[i]) pend[i] = 1'b0;
        end else begin
          if (pend[i]) dly[i]--;
          div_ostream_val[i] = (mode == 1) && !pend[i] && ($urandom_range(0, 3) == 0);
          div_remainder[i*NB +: NB] = '0;
        end
        // request side
        case (mode)
          1:       rdy = ($urandom_range(0, 1) == 1);
          2:       rdy = !(i == 1 && cyc < 5);
          default: rdy = 1'b1;
        endcase
        div_istream_rdy[i] = rdy;
        if (div_istream_val[i] && rdy) begin
          d = int'(dv);
          if (d >= 1024 || dv == '0) bad++;
          else begin
            if (seen[d] || !expected_divisor(d, v)) bad++;
            seen[d] = 1'b1;
          end
          if (div_dividend !== NB'(v)) bad++;
          if (((d - 2) % NL) != i) bad++;
          nissue++;
          pend[i] = 1'b1;
          prem[i] = (dv == '0) ? '0 : (NB'(v) % dv);
          if (mode == 1)           dly[i] = $urandom_range(0, 3);
          else if (mode == 2 && i == 0) dly[i] = 3;
          else                     dly[i] = 0;
        end
      end
      if (mode == 1 && busy && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        value = NB'($urandom_range(0, 400));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    div_istream_rdy = '0;
    div_ostream_val = '0;
    check($sformatf("done v=%0d", v), 32'(done), 1);
    check($sformatf("is_prime v=%0d", v), 32'(is_prime), 32'(ref_prime(v)));
    check($sformatf("factor v=%0d", v), 32'(factor), 32'(ref_factor(v)));
    check($sformatf("issues v=%0d", v), 32'(nissue), 32'(ref_issues(v)));
    check($sformatf("lane_protocol v=%0d", v), 32'(bad), 0);
    if (mode == 0)
      check($sformatf("latency v=%0d", v), 32'(cyc), 32'(3 * ref_rounds(v)));
    if (!done) begin
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
    end
  endtask

  initial begin
    bit ab;
    reset_n = 1'b0;
    start   = 1'b0;
    value   = '0;
    div_istream_rdy = '0;
    div_ostream_val = '0;
    div_remainder   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    reset_n = 1'b1;

    run(7, 0, ab);
    run(9, 0, ab);
    run(15, 0, ab);
    run(0, 0, ab);
    run(1, 0, ab);
    run(2, 0, ab);
    run(3, 0, ab);
    run(4, 0, ab);
    run(25, 0, ab);
    run(11, 2, ab);

    run(97, 3, ab);
    check("reset_in_wait", 32'(ab), 1);
    check_idle("midreset");
    reset_n = 1'b1;
    run(4, 0, ab);
    run(97, 0, ab);

    for (int n = 0; n < 20; n++) run($urandom_range(0, 400), 1, ab);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
